// File: rtl/awb_gain.sv
// Gray-world auto white balance: per-frame R/G/B sums, serial divider for R and B gains, 3-stage gain datapath.
// Latency 3 clocks for data and syncs; no backpressure, one pixel accepted every cycle.
module awb_gain #(
    parameter int source_h = 512,
    parameter int source_v = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        awb_en,
    input  logic        in_vsync,
    input  logic        in_hsync,
    input  logic        in_den,
    input  logic [7:0]  in_data_R,
    input  logic [7:0]  in_data_G,
    input  logic [7:0]  in_data_B,
    output logic        out_vsync,
    output logic        out_hsync,
    output logic        out_den,
    output logic [7:0]  out_data_R,
    output logic [7:0]  out_data_G,
    output logic [7:0]  out_data_B,
    output logic [11:0] out_gain_R,
    output logic [11:0] out_gain_B
);
    localparam int ACC_W = 8 + $clog2(source_h * source_v);

    typedef enum logic [2:0] {IDLE, CHK_R, DIV_R, CHK_B, DIV_B, DONE} state_t;

    logic             vsync_prev;
    logic             vs_rise;
    logic [ACC_W-1:0] sum_r, sum_g, sum_b;
    logic [ACC_W-1:0] snap_r, snap_g, snap_b;

    assign vs_rise = in_vsync & ~vsync_prev;

    // The pixel that arrives with the vsync edge opens the new frame's sums.
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_prev <= 1'b0;
            sum_r      <= '0;
            sum_g      <= '0;
            sum_b      <= '0;
            snap_r     <= '0;
            snap_g     <= '0;
            snap_b     <= '0;
        end else begin
            vsync_prev <= in_vsync;
            if (vs_rise) begin
                snap_r <= sum_r;
                snap_g <= sum_g;
                snap_b <= sum_b;
                sum_r  <= in_den ? ACC_W'(in_data_R) : '0;
                sum_g  <= in_den ? ACC_W'(in_data_G) : '0;
                sum_b  <= in_den ? ACC_W'(in_data_B) : '0;
            end else if (in_den) begin
                sum_r <= sum_r + ACC_W'(in_data_R);
                sum_g <= sum_g + ACC_W'(in_data_G);
                sum_b <= sum_b + ACC_W'(in_data_B);
            end
        end
    end

    state_t           state;
    logic [3:0]       cnt;
    logic [ACC_W-1:0] rem;
    logic [11:0]      dbits;
    logic [11:0]      quo;
    logic             forced;
    logic [11:0]      forced_q;
    logic [11:0]      quo_r, quo_b;
    logic [11:0]      pend_r, pend_b;
    logic [11:0]      gain_r, gain_b;

    logic [ACC_W-1:0] divisor;
    logic [ACC_W:0]   trial;
    logic             trial_ge;
    logic [11:0]      q_next;
    logic [11:0]      q_res;

    // Remainder stays below the divisor because saturating cases are forced in CHK.
    always_comb begin
        divisor  = (state == CHK_B || state == DIV_B) ? snap_b : snap_r;
        trial    = {rem, dbits[11]};
        trial_ge = trial >= {1'b0, divisor};
        q_next   = {quo[10:0], trial_ge};
        q_res    = forced ? forced_q : q_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            dbits    <= '0;
            quo      <= '0;
            forced   <= 1'b0;
            forced_q <= '0;
            quo_r    <= '0;
            quo_b    <= '0;
            pend_r   <= 12'h100;
            pend_b   <= 12'h100;
            gain_r   <= 12'h100;
            gain_b   <= 12'h100;
        end else if (vs_rise) begin
            gain_r <= pend_r;
            gain_b <= pend_b;
            state  <= CHK_R;
        end else begin
            case (state)
                IDLE: ;
                CHK_R, CHK_B: begin
                    forced   <= (divisor == '0) || ({4'b0, snap_g} >= {divisor, 4'b0});
                    forced_q <= (divisor == '0) ? 12'h100 : 12'hFFF;
                    rem      <= {4'b0, snap_g[ACC_W-1:4]};
                    dbits    <= {snap_g[3:0], 8'h00};
                    quo      <= '0;
                    cnt      <= '0;
                    state    <= (state == CHK_R) ? DIV_R : DIV_B;
                end
                DIV_R, DIV_B: begin
                    rem   <= trial_ge ? ACC_W'(trial - {1'b0, divisor}) : trial[ACC_W-1:0];
                    dbits <= {dbits[10:0], 1'b0};
                    quo   <= q_next;
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'd11) begin
                        if (state == DIV_R) begin
                            quo_r <= q_res;
                            state <= CHK_B;
                        end else begin
                            quo_b <= q_res;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    pend_r <= quo_r;
                    pend_b <= quo_b;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_gain_R = gain_r;
    assign out_gain_B = gain_b;

    logic        s1_vs, s1_hs, s1_de, s1_en;
    logic [7:0]  s1_r, s1_g, s1_b;
    logic        s2_vs, s2_hs, s2_de;
    logic [19:0] s2_pr, s2_pb;
    logic [7:0]  s2_g;
    logic [11:0] eff_r, eff_b;

    assign eff_r = s1_en ? gain_r : 12'h100;
    assign eff_b = s1_en ? gain_b : 12'h100;

    function automatic logic [7:0] sat8(input logic [19:0] p);
        return (p[19:16] != 4'd0) ? 8'hFF : p[15:8];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vs <= 1'b0; s1_hs <= 1'b0; s1_de <= 1'b0; s1_en <= 1'b0;
            s1_r  <= '0;   s1_g  <= '0;   s1_b  <= '0;
            s2_vs <= 1'b0; s2_hs <= 1'b0; s2_de <= 1'b0;
            s2_pr <= '0;   s2_pb <= '0;   s2_g  <= '0;
            out_vsync  <= 1'b0;
            out_hsync  <= 1'b0;
            out_den    <= 1'b0;
            out_data_R <= '0;
            out_data_G <= '0;
            out_data_B <= '0;
        end else begin
            s1_vs <= in_vsync;
            s1_hs <= in_hsync;
            s1_de <= in_den;
            s1_en <= awb_en;
            s1_r  <= in_data_R;
            s1_g  <= in_data_G;
            s1_b  <= in_data_B;
            s2_vs <= s1_vs;
            s2_hs <= s1_hs;
            s2_de <= s1_de;
            s2_pr <= 20'(s1_r) * 20'(eff_r);
            s2_pb <= 20'(s1_b) * 20'(eff_b);
            s2_g  <= s1_g;
            out_vsync  <= s2_vs;
            out_hsync  <= s2_hs;
            out_den    <= s2_de;
            out_data_R <= sat8(s2_pr);
            out_data_G <= s2_g;
            out_data_B <= sat8(s2_pb);
        end
    end
endmodule
